// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C types and constants for the slave endpoint and the bus master
package i2c_pkg;
  localparam int I2C_BYTE_W = 8;
  localparam logic [1:0] OP_NO = 2'd0;
  localparam logic [1:0] OP_WR = 2'd1;
  localparam logic [1:0] OP_RD = 2'd2;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK
  } slave_state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: bus line synchronizer with edge pulses; I2C_SLAVE_FILTER_EN adds a 3-sample stability filter
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [1:0] r_sync;
  logic       r_hist;
  logic       w_level;
  // two-flop synchronizer; resets to the idle-high bus level so no edge appears after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], i_line};
`ifdef I2C_SLAVE_FILTER_EN
  logic [1:0] r_samp;
  // two older synchronized samples for the three-sample stability vote
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_samp <= 2'b11;
    else r_samp <= {r_samp[0], r_sync[1]};
  assign w_level = (r_sync[1] == r_samp[0] && r_sync[1] == r_samp[1]) ? r_sync[1] : r_hist;
`else
  assign w_level = r_sync[1];
`endif
  // history flop: previous accepted level, used for rise/fall detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_hist <= 1'b1;
    else r_hist <= w_level;
  assign o_level = w_level;
  assign o_rise  = w_level & ~r_hist;
  assign o_fall  = ~w_level & r_hist;
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit addressed I2C target with open-drain sda; I2C_SLAVE_FILTER_EN enables line glitch filtering
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl,
  inout  wire                   sda,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic                  tx_req,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);
  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [I2C_BYTE_W-1:0] w_byte;
  slave_state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [I2C_BYTE_W-2:0] r_shift, w_shift_nxt;
  logic [I2C_BYTE_W-2:0] r_tx, w_tx_nxt;
  logic [I2C_BYTE_W-1:0] r_rx_data, w_rx_data_nxt;
  logic r_rw, w_rw_nxt;
  logic r_ack, w_ack_nxt;
  logic r_sda_low, w_sda_low_nxt;
  logic r_busy, w_busy_nxt;
  logic r_rx_valid, w_rx_valid_nxt;
  logic r_tx_req, w_tx_req_nxt;

  i2c_line_sync u_scl (.clk(clk), .rst_n(rst_n), .i_line(scl), .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall));
  i2c_line_sync u_sda (.clk(clk), .rst_n(rst_n), .i_line(sda), .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall));

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;
  assign w_byte  = {r_shift, w_sda};

  // next-state and output logic; START/STOP override any bit activity in the same cycle
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = r_tx;
    w_rx_data_nxt  = r_rx_data;
    w_rw_nxt       = r_rw;
    w_ack_nxt      = r_ack;
    w_sda_low_nxt  = r_sda_low;
    w_busy_nxt     = r_busy;
    w_rx_valid_nxt = 1'b0;
    w_tx_req_nxt   = 1'b0;
    if (w_start) begin
      w_state_nxt   = S_ADDR;
      w_cnt_nxt     = 4'd8;
      w_sda_low_nxt = 1'b0;
      w_ack_nxt     = 1'b0;
    end else if (w_stop) begin
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = 4'd8;
      w_sda_low_nxt = 1'b0;
      w_ack_nxt     = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: if (w_scl_rise) begin
          w_shift_nxt = w_byte[I2C_BYTE_W-2:0];
          w_cnt_nxt   = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_cnt_nxt   = 4'd8;
            w_rw_nxt    = w_byte[0];
            w_busy_nxt  = w_byte[7:1] == ADDR;
            w_state_nxt = (w_byte[7:1] == ADDR) ? S_ADDR_ACK : S_IDLE;
          end
        end
        S_ADDR_ACK, S_WR_ACK: if (w_scl_fall) begin
          w_ack_nxt     = ~r_ack;
          w_sda_low_nxt = ~r_ack;
          if (r_ack) begin
            w_cnt_nxt   = 4'd8;
            w_state_nxt = S_WR_DATA;
            if (r_state == S_ADDR_ACK && r_rw) begin
              w_state_nxt   = S_RD_DATA;
              w_tx_nxt      = tx_data[I2C_BYTE_W-2:0];
              w_tx_req_nxt  = 1'b1;
              w_sda_low_nxt = ~tx_data[I2C_BYTE_W-1];
            end
          end
        end
        S_WR_DATA: if (w_scl_rise) begin
          w_shift_nxt = w_byte[I2C_BYTE_W-2:0];
          w_cnt_nxt   = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_cnt_nxt      = 4'd8;
            w_rx_data_nxt  = w_byte;
            w_rx_valid_nxt = 1'b1;
            w_state_nxt    = S_WR_ACK;
          end
        end
        S_RD_DATA: if (w_scl_rise) w_cnt_nxt = r_cnt - 4'd1;
        else if (w_scl_fall) begin
          if (r_cnt == 4'd0) begin
            w_cnt_nxt     = 4'd8;
            w_sda_low_nxt = 1'b0;
            w_state_nxt   = S_RD_ACK;
          end else begin
            w_sda_low_nxt = ~r_tx[I2C_BYTE_W-2];
            w_tx_nxt      = {r_tx[I2C_BYTE_W-3:0], 1'b0};
          end
        end
        S_RD_ACK: if (w_scl_rise && w_sda) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else if (w_scl_fall) begin
          w_cnt_nxt     = 4'd8;
          w_state_nxt   = S_RD_DATA;
          w_tx_nxt      = tx_data[I2C_BYTE_W-2:0];
          w_tx_req_nxt  = 1'b1;
          w_sda_low_nxt = ~tx_data[I2C_BYTE_W-1];
        end
        default: ;
      endcase
    end
  end

  // state and datapath registers; reset releases sda immediately
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd8;
      r_shift    <= '0;
      r_tx       <= '0;
      r_rx_data  <= '0;
      r_rw       <= 1'b0;
      r_ack      <= 1'b0;
      r_sda_low  <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rw       <= w_rw_nxt;
      r_ack      <= w_ack_nxt;
      r_sda_low  <= w_sda_low_nxt;
      r_busy     <= w_busy_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_req   <= w_tx_req_nxt;
    end

  assign sda      = r_sda_low ? 1'b0 : 1'bz;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_req   = r_tx_req;
  assign busy     = r_busy;
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged master with scoreboard queues for written and read bytes
module tb_i2c_slave;
  import i2c_pkg::*;
  localparam int P = 10;
  localparam int Q = 6;
`ifdef I2C_SLAVE_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic m_sda = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_req, rx_valid, busy;
  logic [7:0] rx_data;
  wire sda;
  int n_pass = 0;
  int n_total = 0;
  int n_rx = 0;
  int n_txreq = 0;
  bit busy_seen = 0;
  longint t_rise = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] tx_q[$];

  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;

  i2c_slave dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda), .tx_data(tx_data),
    .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #(P/2) clk = ~clk;

  // monitor: check written bytes against the scoreboard, serve tx_data on tx_req
  initial forever begin : mon
    logic [7:0] e;
    @(negedge clk);
    if (busy) busy_seen = 1;
    if (rx_valid) begin
      n_rx++;
      e = exp_rx.size() != 0 ? exp_rx.pop_front() : 8'hxx;
      n_total++; if (rx_data !== e) $display("FAIL rx_data got=%h exp=%h", rx_data, e); else n_pass++;
      n_total++; if ($time - t_rise != longint'(LAT * P)) $display("FAIL rx_latency got=%0d exp=%0d", $time - t_rise, LAT * P); else n_pass++;
      n_total++; if (tx_req !== 1'b0) $display("FAIL rx_tx_overlap got=%b exp=0", tx_req); else n_pass++;
    end
    if (tx_req) begin
      n_txreq++;
      exp_rd.push_back(tx_data);
      tx_data = tx_q.size() != 0 ? tx_q.pop_front() : 8'h00;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    m_sda = 1; hold(Q); scl = 1; hold(Q); m_sda = 0; hold(Q); scl = 0; hold(Q);
  endtask

  task automatic m_stop();
    m_sda = 0; hold(Q); scl = 1; hold(Q); m_sda = 1; hold(Q);
  endtask

  task automatic bit_out(input logic b, input bit glitch);
    m_sda = b; hold(Q); scl = 1; t_rise = $time; hold(Q);
    if (glitch && b) begin m_sda = 0; hold(1); m_sda = 1; end
    hold(Q); scl = 0; hold(Q);
  endtask

  task automatic bit_in(output logic b);
    m_sda = 1; hold(Q); scl = 1; hold(Q); b = sda; hold(Q); scl = 0; hold(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit glitch, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) bit_out(d[i], glitch);
    bit_in(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic [7:0] v;
    logic b;
    for (int i = 7; i >= 0; i--) begin bit_in(b); v[i] = b; end
    bit_out(~ack, 1'b0);
    d = v;
  endtask

  task automatic test_reset();
    rst_n = 0; hold(4);
    n_total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got=%h exp=00", rx_data); else n_pass++;
    n_total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); else n_pass++;
    n_total++; if (tx_req !== 1'b0) $display("FAIL reset_tx_req got=%b exp=0", tx_req); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (sda !== 1'b1) $display("FAIL reset_sda got=%b exp=1", sda); else n_pass++;
    rst_n = 1; hold(4);
  endtask

  task automatic test_write();
    logic ack;
    int n0 = n_rx;
    m_start();
    write_byte(8'hA0, 0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL wr_addr_ack got=%b exp=1", ack); else n_pass++;
    exp_rx.push_back(8'h3C); write_byte(8'h3C, 0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL wr_data0_ack got=%b exp=1", ack); else n_pass++;
    exp_rx.push_back(8'hC3); write_byte(8'hC3, 0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL wr_data1_ack got=%b exp=1", ack); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL wr_busy_open got=%b exp=1", busy); else n_pass++;
    m_stop(); hold(4);
    n_total++; if (busy !== 1'b0) $display("FAIL wr_busy_stop got=%b exp=0", busy); else n_pass++;
    n_total++; if (n_rx - n0 != 2) $display("FAIL wr_rx_count got=%0d exp=2", n_rx - n0); else n_pass++;
    n_total++; if (exp_rx.size() != 0) $display("FAIL wr_rx_pending got=%0d exp=0", exp_rx.size()); else n_pass++;
  endtask

  task automatic test_addr_nack();
    logic ack;
    int n0 = n_rx;
    busy_seen = 0;
    m_start();
    write_byte(8'hA2, 0, ack);
    n_total++; if (ack !== 1'b0) $display("FAIL nack_ack got=%b exp=0", ack); else n_pass++;
    m_stop(); hold(4);
    n_total++; if (busy_seen !== 1'b0) $display("FAIL nack_busy got=%b exp=0", busy_seen); else n_pass++;
    n_total++; if (n_rx != n0) $display("FAIL nack_rx_count got=%0d exp=%0d", n_rx, n0); else n_pass++;
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d, e;
    int t0 = n_txreq;
    exp_rd.delete(); tx_q.delete();
    tx_data = 8'h5A; tx_q.push_back(8'hFF);
    m_start();
    write_byte(8'hA1, 0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL rd_addr_ack got=%b exp=1", ack); else n_pass++;
    read_byte(d, 1'b1);
    e = exp_rd.size() != 0 ? exp_rd.pop_front() : 8'hxx;
    n_total++; if (d !== e || d !== 8'h5A) $display("FAIL rd_byte0 got=%h exp=%h", d, e); else n_pass++;
    read_byte(d, 1'b0);
    e = exp_rd.size() != 0 ? exp_rd.pop_front() : 8'hxx;
    n_total++; if (d !== e || d !== 8'hFF) $display("FAIL rd_byte1 got=%h exp=%h", d, e); else n_pass++;
    n_total++; if (dut.r_state !== S_IDLE) $display("FAIL rd_state got=%0d exp=%0d", dut.r_state, S_IDLE); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rd_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (n_txreq - t0 != 2) $display("FAIL rd_txreq_count got=%0d exp=2", n_txreq - t0); else n_pass++;
    m_stop(); hold(4);
  endtask

  task automatic test_back_to_back();
    logic ack;
    logic [7:0] d, e;
    exp_rd.delete(); tx_q.delete();
    m_start();
    write_byte(8'hA0, 0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL rs_wr_addr_ack got=%b exp=1", ack); else n_pass++;
    exp_rx.push_back(8'h11); write_byte(8'h11, 0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL rs_wr_data_ack got=%b exp=1", ack); else n_pass++;
    m_start();
    n_total++; if (busy !== 1'b1) $display("FAIL rs_busy_restart got=%b exp=1", busy); else n_pass++;
    tx_data = 8'hC7;
    write_byte(8'hA1, 0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL rs_rd_addr_ack got=%b exp=1", ack); else n_pass++;
    read_byte(d, 1'b0);
    e = exp_rd.size() != 0 ? exp_rd.pop_front() : 8'hxx;
    n_total++; if (d !== e || d !== 8'hC7) $display("FAIL rs_rd_byte got=%h exp=%h", d, e); else n_pass++;
    n_total++; if (rx_data !== 8'h11) $display("FAIL rs_rx_data got=%h exp=11", rx_data); else n_pass++;
    m_stop(); hold(4);
    n_total++; if (busy !== 1'b0) $display("FAIL rs_busy_stop got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    logic ack, b;
    exp_rd.delete(); tx_q.delete();
    tx_data = 8'hE0;
    m_start();
    write_byte(8'hA1, 0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL rst_addr_ack got=%b exp=1", ack); else n_pass++;
    for (int i = 0; i < 3; i++) bit_in(b);
    m_sda = 1; hold(Q); scl = 1; hold(Q);
    n_total++; if (sda !== 1'b0) $display("FAIL rst_bit4_driven got=%b exp=0", sda); else n_pass++;
    #3 rst_n = 0;
    #1;
    n_total++; if (sda !== 1'b1) $display("FAIL rst_sda_release got=%b exp=1", sda); else n_pass++;
    n_total++; if (rx_data !== 8'h00) $display("FAIL rst_rx_data got=%h exp=00", rx_data); else n_pass++;
    n_total++; if (busy !== 1'b0 || tx_req !== 1'b0 || rx_valid !== 1'b0) $display("FAIL rst_outputs got=%b%b%b exp=000", busy, tx_req, rx_valid); else n_pass++;
    hold(2); scl = 0; hold(Q); rst_n = 1; hold(Q);
    exp_rd.delete();
    m_start();
    write_byte(8'hA0, 0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL rst_next_addr_ack got=%b exp=1", ack); else n_pass++;
    exp_rx.push_back(8'h5E); write_byte(8'h5E, 0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL rst_next_data_ack got=%b exp=1", ack); else n_pass++;
    m_stop(); hold(4);
  endtask

`ifdef I2C_SLAVE_FILTER_EN
  task automatic test_filter_glitch();
    logic ack;
    m_start();
    write_byte(8'hA0, 0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL flt_addr_ack got=%b exp=1", ack); else n_pass++;
    exp_rx.push_back(8'hFF); write_byte(8'hFF, 1, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL flt_data_ack got=%b exp=1", ack); else n_pass++;
    n_total++; if (dut.r_state !== S_WR_DATA) $display("FAIL flt_state got=%0d exp=%0d", dut.r_state, S_WR_DATA); else n_pass++;
    m_stop(); hold(4);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_addr_nack();
    test_read();
    test_back_to_back();
    test_reset_mid_read();
`ifdef I2C_SLAVE_FILTER_EN
    test_filter_glitch();
`endif
    hold(10);
    n_total++; if (exp_rx.size() != 0) $display("FAIL rx_pending_end got=%0d exp=0", exp_rx.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
